// File: rtl/reg_dump_tx_pkg.sv
// Purpose : shared types and constants for the register dump serializer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding (3-bit), BYTE_WIDTH, BYTES_PER_WORD derivation.
package reg_dump_tx_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SEND    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Number of bytes a register word splits into; DATA_WIDTH is a multiple of 8.
    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/reg_dump_tx_if.sv
// Purpose : groups the bank debug port, the UART TX byte stream and status.
// Latency : n/a (wires only).
// Backpressure: i_tx_ready stalls the byte stream; no other flow control.
//
// slave  : the dump engine (consumes start/debug word/ready, drives the rest).
// master : the environment (bank + UART TX + requester).
interface reg_dump_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_reg_debug;
    logic                  i_tx_ready;
    logic                  o_debug;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_reg_debug, i_tx_ready,
        output o_debug, o_tx_data, o_tx_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_reg_debug, i_tx_ready,
        input  o_debug, o_tx_data, o_tx_valid, o_busy, o_done
    );
endinterface

// File: rtl/reg_dump_tx_word_byte_mux.sv
// Purpose : selects byte byte_idx_i of a captured word (byte 0 = LSB).
// Latency : combinational.
// Backpressure: none.
//
// Ports: word_i (captured word), byte_idx_i (byte lane), byte_o (selected byte).
module reg_dump_tx_word_byte_mux
    import reg_dump_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 2
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [IDX_W-1:0]      byte_idx_i,
    output logic [BYTE_WIDTH-1:0] byte_o
);

    assign byte_o = word_i[int'(byte_idx_i) * BYTE_WIDTH +: BYTE_WIDTH];

endmodule

// File: rtl/reg_dump_tx.sv
// Purpose : walks every register through the bank debug counter and streams each word LSB-first as bytes.
// Latency : first byte valid 2 cycles after start; one byte per cycle while ready is high.
// Backpressure: i_tx_ready low holds o_tx_valid/o_tx_data stable indefinitely; start ignored while busy.
//
// Ports: i_clock/i_reset (async active-low) plain; bus (slave modport) carries start, debug word,
// debug-advance pulse, byte stream and busy/done status.
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic         i_clock,
    input  logic         i_reset,
    reg_dump_tx_if.slave bus
);

    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int REG_IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [REG_IDX_W-1:0]  LAST_REG  = REG_IDX_W'(NUM_REGS - 1);

    state_e                  state_q;
    logic [REG_IDX_W-1:0]    reg_idx_q;
    logic [REG_IDX_W-1:0]    reg_idx_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q;
    logic [BYTE_IDX_W-1:0]   byte_idx_d;
    logic [DATA_WIDTH-1:0]   word_q;
    logic                    debug_q;
    logic                    tx_valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [BYTE_WIDTH-1:0]   sel_byte;

    assign reg_idx_d  = reg_idx_q + 1'b1;
    assign byte_idx_d = byte_idx_q + 1'b1;

    reg_dump_tx_word_byte_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (BYTE_IDX_W)
    ) u_mux (
        .word_i     (word_q),
        .byte_idx_i (byte_idx_q),
        .byte_o     (sel_byte)
    );

    // Outputs are registered alongside the state: each flag is set on the
    // transition into the state that owns it and cleared on the way out.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            debug_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_q   <= ST_CAPTURE;
                        reg_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // The bank counter already points at reg_idx_q here.
                    word_q     <= bus.i_reg_debug;
                    byte_idx_q <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.i_tx_ready) begin
                        if (byte_idx_q == LAST_BYTE) begin
                            tx_valid_q <= 1'b0;
                            debug_q    <= 1'b1;
                            state_q    <= ST_ADVANCE;
                        end else begin
                            byte_idx_q <= byte_idx_d;
                        end
                    end
                end
                ST_ADVANCE: begin
                    // The bank steps on the negedge of this cycle, so the next
                    // word is ready for CAPTURE without a settle cycle. On the
                    // last register the counter wraps back to 0.
                    debug_q <= 1'b0;
                    if (reg_idx_q == LAST_REG) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        reg_idx_q <= reg_idx_d;
                        state_q   <= ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    debug_q    <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_debug    = debug_q;
    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_tx_data  = tx_valid_q ? sel_byte : '0;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Purpose : self-checking bench for reg_dump_tx with a bank model and a byte-stream reference.
// Latency : n/a.
// Backpressure: ready driven as always-high, a directed 5-cycle stall, or 50% random.
module tb_reg_dump_tx;

    localparam int DW    = 32;
    localparam int NR    = 32;
    localparam int BPW   = DW / 8;
    localparam int TOTAL = NR * BPW;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;

    reg_dump_tx_if #(.DATA_WIDTH(DW)) bus ();

    reg_dump_tx #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // ---------------- bank model: counter steps on negedge while o_debug ----
    logic [DW-1:0] bank [NR];
    int            bank_cnt;

    always @(negedge i_clock or negedge i_reset) begin
        if (!i_reset)         bank_cnt <= 0;
        else if (bus.o_debug) bank_cnt <= (bank_cnt + 1) % NR;
    end

    assign bus.i_reg_debug = bank[bank_cnt];

    // Reference: stream byte k is byte (k mod BPW) of register (k / BPW) mod NR.
    function automatic logic [7:0] exp_byte(input int k);
        int            r = (k / BPW) % NR;
        int            b = k % BPW;
        logic [DW-1:0] w = bank[r];
        return 8'(w >> (8 * b));
    endfunction

    // ---------------- monitor (owns the counters) ----------------------------
    int         accepted     = 0;
    int         debug_cnt    = 0;
    int         done_cnt     = 0;
    int         busy_cycles  = 0;
    int         stall_cycles = 0;
    int         base         = 0;   // owned by the main sequence
    logic [7:0] rx_q [$];

    always @(negedge i_clock) begin
        if (i_reset) begin
            if (bus.o_tx_valid) begin
                chk("stream_byte", bus.o_tx_data, exp_byte(accepted - base));
                if (bus.i_tx_ready) begin
                    rx_q.push_back(bus.o_tx_data);
                    accepted++;
                end else begin
                    stall_cycles++;
                end
            end
            if (bus.o_debug) begin
                debug_cnt++;
                chk("debug_in_send", bus.o_tx_valid, 1'b0);
            end
            if (bus.o_done) done_cnt++;
            if (bus.o_busy) busy_cycles++;
        end
    end

    // ---------------- ready driver (sole writer of i_tx_ready) ---------------
    int rand_rdy   = 0;
    int stall_at   = -1;
    int stall_req  = 0;
    int stall_used = 0;

    always @(posedge i_clock) begin
        #1;
        if (rand_rdy != 0) begin
            bus.i_tx_ready = 1'($urandom_range(0, 1));
        end else if (stall_used < stall_req && bus.o_tx_valid && (accepted - base) == stall_at) begin
            bus.i_tx_ready = 1'b0;
            stall_used++;
        end else begin
            bus.i_tx_ready = 1'b1;
        end
    end

    // ---------------- main sequence helpers ----------------------------------
    int db0, dn0, bc0, sc0;

    task automatic tick();
        @(negedge i_clock);
        #1;
    endtask

    task automatic snap();
        base = accepted;
        db0  = debug_cnt;
        dn0  = done_cnt;
        bc0  = busy_cycles;
        sc0  = stall_cycles;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while ((done_cnt - dn0) < target && n < 3000) begin
            tick();
            n++;
        end
        chk("done_timeout", 1'((done_cnt - dn0) >= target), 1'b1);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while ((accepted - base) < target && n < 3000) begin
            tick();
            n++;
        end
        chk("bytes_timeout", 1'((accepted - base) >= target), 1'b1);
    endtask

    task automatic stream_check(input string tag, input int n, input int from);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (from + k >= rx_q.size() || rx_q[from + k] !== exp_byte(k)) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_debug"}, bus.o_debug, 1'b0);
        chk({tag, "_valid"}, bus.o_tx_valid, 1'b0);
        chk({tag, "_data"},  bus.o_tx_data, 8'h00);
        chk({tag, "_busy"},  bus.o_busy, 1'b0);
        chk({tag, "_done"},  bus.o_done, 1'b0);
    endtask

    task automatic word_at(input int idx, output logic [31:0] w);
        w = {rx_q[idx + 3], rx_q[idx + 2], rx_q[idx + 1], rx_q[idx]};
    endtask

    // ---------------- directed sequence --------------------------------------
    initial begin
        int            b1;
        int            gap;
        int            dbs;
        int            bad;
        logic [31:0]   w;

        bus.i_start = 1'b0;
        for (int i = 0; i < NR; i++) bank[i] = '0;
        bank[1]  = 32'd1;
        bank[2]  = 32'd2;
        bank[10] = 32'd4;
        bank[31] = 32'd256;

        #2 i_reset = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        i_reset = 1'b1;
        tick();
        tick();

        // ---- dump 1: ready high, fixed bank ----
        snap();
        b1 = base;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("lat_capture_valid", bus.o_tx_valid, 1'b0);
        chk("lat_capture_busy",  bus.o_busy, 1'b1);
        tick();
        chk("lat_send_valid", bus.o_tx_valid, 1'b1);
        chk("lat_send_data",  bus.o_tx_data, 8'h00);
        wait_done(1);
        chk("d1_bytes",  accepted - base, TOTAL);
        chk("d1_debug",  debug_cnt - db0, NR);
        chk("d1_done",   done_cnt - dn0, 1);
        chk("d1_busy",   busy_cycles - bc0, NR * (BPW + 2) + 1);
        chk("d1_bankcnt", bank_cnt, 0);
        word_at(base + 4, w);   chk("d1_r1",  w, 32'h0000_0001);
        word_at(base + 40, w);  chk("d1_r10", w, 32'h0000_0004);
        word_at(base + 124, w); chk("d1_r31", w, 32'h0000_0100);
        stream_check("d1_stream", TOTAL, base);
        tick();
        chk("d1_idle_busy", bus.o_busy, 1'b0);

        // ---- dump 2: 5-cycle stall on byte 42 (r10 byte 2), start at byte 60 ----
        stall_at  = 42;
        stall_req = 5;
        snap();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_bytes(60);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_done(1);
        repeat (10) tick();
        chk("d2_done",   done_cnt - dn0, 1);
        chk("d2_bytes",  accepted - base, TOTAL);
        chk("d2_stall",  stall_cycles - sc0, 5);
        chk("d2_debug",  debug_cnt - db0, NR);
        chk("d2_busy",   bus.o_busy, 1'b0);
        stream_check("d2_stream", TOTAL, base);

        // ---- dump 3: reset while sending r5 ----
        snap();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_bytes(5 * BPW + 1);
        i_reset = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        dbs = debug_cnt;
        repeat (3) tick();
        i_reset = 1'b1;
        repeat (3) tick();
        chk("midreset_nodebug", debug_cnt, dbs);
        chk("midreset_bankcnt", bank_cnt, 0);

        // ---- dump 4: random ready, same bank; stream must equal dump 1 ----
        rand_rdy = 1;
        snap();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_done(1);
        rand_rdy = 0;
        chk("d4_bytes", accepted - base, TOTAL);
        chk("d4_debug", debug_cnt - db0, NR);
        stream_check("d4_stream", TOTAL, base);
        bad = 0;
        for (int k = 0; k < TOTAL; k++) if (rx_q[b1 + k] !== rx_q[base + k]) bad++;
        chk("d4_same_as_d1", bad, 0);
        repeat (2) tick();

        // ---- dumps 5/6: random bank, start held high ----
        for (int i = 0; i < NR; i++) bank[i] = $urandom;
        snap();
        bus.i_start = 1'b1;
        wait_done(1);
        gap = 0;
        tick();
        while (bus.o_busy == 1'b0 && gap < 10) begin
            gap++;
            tick();
        end
        chk("held_gap", gap, 1);
        wait_done(2);
        bus.i_start = 1'b0;
        repeat (3) tick();
        chk("held_bytes", accepted - base, 2 * TOTAL);
        chk("held_done",  done_cnt - dn0, 2);
        chk("held_debug", debug_cnt - db0, 2 * NR);
        chk("held_busy",  bus.o_busy, 1'b0);
        stream_check("held_stream", 2 * TOTAL, base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
- Debug-path consumer of the register bank's debug read port.
- On a start request it walks all architectural registers through the bank's debug counter and captures each word.
- It serializes each word into bytes on a valid/ready stream toward the debug UART transmitter.
- Sits between the register bank (debug output and debug-advance input) and the UART TX.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 32, registers dumped per request; must match the bank depth.
- BYTES_PER_WORD, DATA_WIDTH/8, derived; not overridden.

Ports:
- i_clock  input  1  system clock; all state updates on posedge.
- i_reset  input  1  asynchronous, active-low reset.
- i_start  input  1  dump request; sampled in IDLE only.
- i_reg_debug  input  DATA_WIDTH  word currently selected by the bank's debug counter.
- i_tx_ready  input  1  UART TX can accept a byte this cycle.
- o_debug  output  1  one-cycle pulse that advances the bank's debug counter.
- o_tx_data  output  8  byte to transmit.
- o_tx_valid  output  1  o_tx_data is valid.
- o_busy  output  1  dump in progress (any state except IDLE).
- o_done  output  1  one-cycle pulse when the last byte of the last register has been accepted.

Behaviour:
- Reset (i_reset=0, async): state=IDLE, reg_idx=0, byte_idx=0, word_q=0. All outputs are 0: o_debug, o_tx_valid, o_tx_data, o_busy, o_done. Reset mid-dump aborts immediately; no further o_debug pulses are issued.
- The system must reset the bank's debug counter in the same reset event so that both start at register 0.
- FSM states: IDLE, CAPTURE, SEND, ADVANCE, DONE.
- IDLE: i_start=1 -> CAPTURE; reg_idx=0.
- CAPTURE: one cycle; word_q<=i_reg_debug; byte_idx<=0 -> SEND.
- SEND:
  - o_tx_valid=1; o_tx_data=word_q[8*byte_idx +: 8], least-significant byte first.
  - A transfer occurs on a posedge with o_tx_valid=1 and i_tx_ready=1.
  - While i_tx_ready=0, o_tx_valid stays 1 and o_tx_data stays stable; no timeout.
  - On transfer with byte_idx<BYTES_PER_WORD-1: byte_idx++ and stay in SEND. Back-to-back bytes, one per cycle, when ready is held high.
  - On transfer of the last byte: go to ADVANCE.
- ADVANCE:
  - o_debug=1 for exactly one cycle. The bank increments its counter on the negedge inside this cycle, so i_reg_debug is valid at the next posedge; no extra settle cycle.
  - If reg_idx==NUM_REGS-1: go to DONE. The bank counter has wrapped to 0, so exactly NUM_REGS pulses are issued per dump.
  - Otherwise reg_idx++ and go to CAPTURE.
- DONE: o_done=1 for one cycle, o_busy still 1 -> IDLE.
- i_start while busy is ignored; no queuing.
- i_start held high: a new dump starts from IDLE, giving at least one idle cycle between dumps.
- Latency from start to first byte valid: 2 cycles (IDLE->CAPTURE->SEND).
- Total bytes per dump: NUM_REGS*BYTES_PER_WORD (128 by default).
- Minimum dump duration with ready always high: NUM_REGS*(BYTES_PER_WORD+2)+2 cycles (194 by default).
- All outputs are registered or decoded from registered state only; no combinational path from i_tx_ready to o_tx_valid.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams), BYTE_WIDTH=8, and the BYTES_PER_WORD derivation.
- Optional sub-module word_byte_mux: combinational selection of byte byte_idx from word_q. Everything else stays in one module.

Test Plan:
- Bank model with r1=1, r2=2, r10=4, r31=256, others 0; pulse i_start with ready always 1. Required: 128 bytes; bytes 4..7 = 01 00 00 00; bytes 40..43 = 04 00 00 00; bytes 124..127 = 00 01 00 00; exactly 32 o_debug pulses; o_done once at the end; bank counter back at 0.
- Hold ready=0 for 5 cycles while byte 2 of r10 is presented. Required: o_tx_valid=1 and o_tx_data=00 stable for all 5 cycles; no duplicated or lost byte.
- Pulse i_start again during a dump at byte 60. Required: no effect; a single o_done; 128 bytes total.
- Assert i_reset=0 while in SEND for r5. Required: all outputs 0 at once, state IDLE. A new i_start then dumps from r0 correctly.
- Hold i_start high continuously. Required: back-to-back dumps, each 128 bytes, with o_busy=0 for exactly one cycle between them.
- Toggle ready randomly at 50% for one full dump. Required: byte stream identical to the first scenario; o_debug never asserted in SEND.
